// File: rtl/ctrl_pkg.sv
// Shared types and constants for the systolic array control sequencer.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    // B operand layout selector values
    localparam logic B_COL_K = 1'b0;
    localparam logic B_ROW_K = 1'b1;

    localparam int unsigned CTRL_PERF_W = 32;

    typedef logic [CTRL_PERF_W-1:0] perf_cnt_t;

endpackage

// File: rtl/ctrl_loop_cnt.sv
// Three-level nested loop counter (r outermost, then c, then k innermost).
module ctrl_loop_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] lim_k,
    input  logic [CNT_W-1:0] lim_c,
    input  logic [CNT_W-1:0] lim_r,
    output logic [CNT_W-1:0] k_cnt,
    output logic [CNT_W-1:0] c_cnt,
    output logic [CNT_W-1:0] r_cnt,
    output logic             tile_last,
    output logic             job_last
);

    logic c_last;
    logic r_last;

    // Terminal-count flags for each loop level
    always_comb begin
        tile_last = (k_cnt == lim_k - CNT_W'(1));
        c_last    = (c_cnt == lim_c - CNT_W'(1));
        r_last    = (r_cnt == lim_r - CNT_W'(1));
        job_last  = tile_last && c_last && r_last;
    end

    // Nested increment with wrap to zero at each level's limit
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            k_cnt <= '0;
            c_cnt <= '0;
            r_cnt <= '0;
        end else if (advance) begin
            if (tile_last) begin
                k_cnt <= '0;
                if (c_last) begin
                    c_cnt <= '0;
                    if (r_last) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else begin
                    c_cnt <= c_cnt + CNT_W'(1);
                end
            end else begin
                k_cnt <= k_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Address/init sequencer for an N1 x N2 systolic matrix-multiply array.
// Optional feature macro: CTRL_PERF_CNT_EN adds the stall_cycles counter port.
module systolic_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned N1           = 4,
    parameter int unsigned N2           = 4,
    parameter int unsigned MATRIXSIZE_W = 16,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MATRIXSIZE_W-1:0] M1dN1,
    input  logic [MATRIXSIZE_W-1:0] M2,
    input  logic [MATRIXSIZE_W-1:0] M3dN2,
    input  logic [ADDR_W-1:0]       a_base,
    input  logic [ADDR_W-1:0]       b_base,
    input  logic                    b_kmajor,
    input  logic                    stall,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr_A,
    output logic [ADDR_W-1:0]       rd_addr_B,
    output logic [N1*N2-1:0]        init,
    output logic                    busy,
    output logic                    done
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CTRL_PERF_W-1:0]  stall_cycles
`endif
);

    localparam int unsigned MW        = MATRIXSIZE_W;
    localparam int unsigned DRAIN_LEN = N1 + N2;
    localparam int unsigned DRAIN_W   = $clog2(DRAIN_LEN);
    // Stage N1+N2 coincides with the final drain cycle and drives no PE,
    // so only stages 1..N1+N2-1 are held in the register.
    localparam int unsigned SR_W      = N1 + N2 - 1;
    localparam int unsigned FULL_W    = ((ADDR_W > 2 * MW) ? ADDR_W : 2 * MW) + 1;

    ctrl_state_t         state;
    logic [MW-1:0]       m1_q;
    logic [MW-1:0]       m2_q;
    logic [MW-1:0]       m3_q;
    logic [ADDR_W-1:0]   a_base_q;
    logic [ADDR_W-1:0]   b_base_q;
    logic                b_kmajor_q;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [SR_W-1:0]     skew_sr;

    logic [MW-1:0]       k_cnt;
    logic [MW-1:0]       c_cnt;
    logic [MW-1:0]       r_cnt;
    logic                tile_last;
    logic                job_last;

    logic                start_acc;
    logic                zero_dim;
    logic                issue;
    logic                tile_evt;
    logic [FULL_W-1:0]   addr_a_full;
    logic [FULL_W-1:0]   addr_b_full;

    // Handshake and issue qualifiers
    always_comb begin
        start_acc = (state == IDLE) && start;
        zero_dim  = (M1dN1 == '0) || (M2 == '0) || (M3dN2 == '0);
        issue     = (state == RUN) && !stall;
        tile_evt  = issue && tile_last;
        rd_en     = issue;
    end

    ctrl_loop_cnt #(
        .CNT_W (MW)
    ) u_loop_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc),
        .advance   (issue),
        .lim_k     (m2_q),
        .lim_c     (m3_q),
        .lim_r     (m1_q),
        .k_cnt     (k_cnt),
        .c_cnt     (c_cnt),
        .r_cnt     (r_cnt),
        .tile_last (tile_last),
        .job_last  (job_last)
    );

    // Operand addresses at full width, wrapping modulo 2^ADDR_W
    always_comb begin
        addr_a_full = FULL_W'(a_base_q) + FULL_W'(r_cnt) * FULL_W'(m2_q) + FULL_W'(k_cnt);
        addr_b_full = FULL_W'(b_base_q) + FULL_W'(c_cnt) * FULL_W'(m2_q) + FULL_W'(k_cnt);
        case (b_kmajor_q)
            B_COL_K: addr_b_full = FULL_W'(b_base_q) + FULL_W'(c_cnt) * FULL_W'(m2_q) + FULL_W'(k_cnt);
            B_ROW_K: addr_b_full = FULL_W'(b_base_q) + FULL_W'(k_cnt) * FULL_W'(m3_q) + FULL_W'(c_cnt);
        endcase
        rd_addr_A = ADDR_W'(addr_a_full);
        rd_addr_B = ADDR_W'(addr_b_full);
    end

    // Control FSM with configuration latch and registered busy/done
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            drain_cnt  <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            m3_q       <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            b_kmajor_q <= B_COL_K;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m1_q       <= M1dN1;
                        m2_q       <= M2;
                        m3_q       <= M3dN2;
                        a_base_q   <= a_base;
                        b_base_q   <= b_base;
                        b_kmajor_q <= b_kmajor;
                        if (zero_dim) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && job_last) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (drain_cnt == DRAIN_W'(DRAIN_LEN - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DRAIN_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Init skew line: tile-end events ripple one stage per unstalled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            skew_sr <= '0;
        end else if (!stall) begin
            skew_sr <= SR_W'({skew_sr, tile_evt});
        end
    end

    // PE(i,j) sees the tile-end event i+j+1 advancing cycles later
    always_comb begin
        init = '0;
        for (int i = 0; i < int'(N1); i++) begin
            for (int j = 0; j < int'(N2); j++) begin
                init[i*int'(N2)+j] = skew_sr[i+j];
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Saturating count of stalled RUN/DRAIN cycles, cleared per job
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_cycles <= '0;
        end else if (((state == RUN) || (state == DRAIN)) && stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CTRL_PERF_W'(1);
        end
    end
`else
    // No stall statistics in this build
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl with N1 = N2 = 2 and directed jobs.
module tb_systolic_ctrl;

    localparam int unsigned N1 = 2;
    localparam int unsigned N2 = 2;
    localparam int unsigned MW = 16;
    localparam int unsigned AW = 16;

    logic            clk;
    logic            rst;
    logic            start;
    logic [MW-1:0]   M1dN1;
    logic [MW-1:0]   M2;
    logic [MW-1:0]   M3dN2;
    logic [AW-1:0]   a_base;
    logic [AW-1:0]   b_base;
    logic            b_kmajor;
    logic            stall;
    logic            rd_en;
    logic [AW-1:0]   rd_addr_A;
    logic [AW-1:0]   rd_addr_B;
    logic [N1*N2-1:0] init;
    logic            busy;
    logic            done;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0]     stall_cycles;
`endif

    systolic_ctrl #(
        .N1           (N1),
        .N2           (N2),
        .MATRIXSIZE_W (MW),
        .ADDR_W       (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .M1dN1        (M1dN1),
        .M2           (M2),
        .M3dN2        (M3dN2),
        .a_base       (a_base),
        .b_base       (b_base),
        .b_kmajor     (b_kmajor),
        .stall        (stall),
        .rd_en        (rd_en),
        .rd_addr_A    (rd_addr_A),
        .rd_addr_B    (rd_addr_B),
        .init         (init),
        .busy         (busy),
        .done         (done)
`ifdef CTRL_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    typedef struct {
        int cyc;
        int a;
        int b;
    } exp_t;

    exp_t addr_q [$];
    int   init0_q [$];
    int   init3_q [$];
    int   done_q [$];

    // Hand-computed reference sequences for the 2x3x2 job
    int basic_a     [12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int basic_b     [12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    int km_a        [12] = '{100, 101, 102, 100, 101, 102, 103, 104, 105, 103, 104, 105};
    int km_b        [12] = '{200, 202, 204, 201, 203, 205, 200, 202, 204, 201, 203, 205};
    int stall_iss   [12] = '{1, 2, 3, 4, 8, 9, 10, 11, 12, 13, 14, 15};
    int init0_plain [4]  = '{4, 7, 10, 13};
    int init0_stall [4]  = '{4, 10, 13, 16};
    int init3_plain [4]  = '{6, 9, 12, 15};
    int init3_stall [4]  = '{9, 12, 15, 18};

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t0       = 0;
    int busy_lo  = 1;
    int busy_hi  = 0;
    bit mon_en   = 0;
    bit job_done = 0;
    bit init0_prev = 0;
    bit init3_prev = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d of job)", name, act, exp, cyc - t0);
        end
    endtask

    // Monitor: pop expectations whenever the DUT presents an event
    always @(negedge clk) begin
        int   rel;
        exp_t e;
        int   x;
        if (mon_en) begin
            rel = cyc - t0;
            chk("busy", longint'(busy), longint'((rel >= busy_lo) && (rel <= busy_hi)));
            if (rd_en) begin
                if (addr_q.size() == 0) begin
                    chk("rd_en_unexpected", 1, 0);
                end else begin
                    e = addr_q.pop_front();
                    chk("rd_cycle", rel, e.cyc);
                    chk("rd_addr_A", longint'(rd_addr_A), e.a);
                    chk("rd_addr_B", longint'(rd_addr_B), e.b);
                end
            end
            if (init[0] && !init0_prev) begin
                if (init0_q.size() == 0) begin
                    chk("init0_unexpected", 1, 0);
                end else begin
                    x = init0_q.pop_front();
                    chk("init0_cycle", rel, x);
                end
            end
            if (init[3] && !init3_prev) begin
                if (init3_q.size() == 0) begin
                    chk("init3_unexpected", 1, 0);
                end else begin
                    x = init3_q.pop_front();
                    chk("init3_cycle", rel, x);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    x = done_q.pop_front();
                    chk("done_cycle", rel, x);
                end
                job_done = 1'b1;
            end
            init0_prev = init[0];
            init3_prev = init[3];
        end
    end

    // Issue one 2x3x2 job (variants selected by flags); called at posedge+1
    task automatic run_job(input bit kmaj, input bit stl, input bit zero,
                           input int restart_at, input int rst_at);
        int   n_iss;
        int   n_ev;
        exp_t e;
        t0       = cyc;
        job_done = 1'b0;
        n_iss = zero ? 0 : ((rst_at > 0) ? rst_at : 12);
        n_ev  = zero ? 0 : ((rst_at > 0) ? 1 : 4);
        for (int i = 0; i < n_iss; i++) begin
            e.cyc = stl ? stall_iss[i] : i + 1;
            e.a   = kmaj ? km_a[i] : basic_a[i];
            e.b   = kmaj ? km_b[i] : basic_b[i];
            addr_q.push_back(e);
        end
        for (int i = 0; i < n_ev; i++) begin
            init0_q.push_back(stl ? init0_stall[i] : init0_plain[i]);
            init3_q.push_back(stl ? init3_stall[i] : init3_plain[i]);
        end
        if (rst_at == 0) done_q.push_back(zero ? 1 : (stl ? 20 : 17));
        busy_lo = 1;
        busy_hi = zero ? 0 : ((rst_at > 0) ? rst_at : (stl ? 19 : 16));
        M1dN1    = 16'd2;
        M2       = zero ? 16'd0 : 16'd3;
        M3dN2    = 16'd2;
        a_base   = kmaj ? 16'd100 : 16'd0;
        b_base   = kmaj ? 16'd200 : 16'd0;
        b_kmajor = kmaj;
        start    = 1'b1;
        stall    = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            // Scramble configuration: only the accepted start may sample it
            M1dN1    = 16'd7;
            M2       = 16'd9;
            M3dN2    = 16'd5;
            a_base   = 16'd3333;
            b_base   = 16'd4444;
            b_kmajor = ~kmaj;
            start    = (n == restart_at);
            stall    = stl && (n >= 5) && (n <= 7);
            rst      = (rst_at > 0) && (n == rst_at);
            if ((rst_at > 0) && (n == rst_at + 1)) break;
            if (job_done) break;
            if (n == 60) chk("job_timeout", 0, 1);
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        M1dN1    = '0;
        M2       = '0;
        M3dN2    = '0;
        a_base   = '0;
        b_base   = '0;
        b_kmajor = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rd_en", longint'(rd_en), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_init", longint'(init), 0);
        chk("reset_addr_A", longint'(rd_addr_A), 0);
        chk("reset_addr_B", longint'(rd_addr_B), 0);
`ifdef CTRL_PERF_CNT_EN
        chk("reset_stall_cycles", longint'(stall_cycles), 0);
`endif
        mon_en = 1'b1;

        // Stall while idle must not disturb anything
        @(posedge clk);
        #1;
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b0;

        // Basic job, then back-to-back k-major job, stalled job, zero job
        run_job(1'b0, 1'b0, 1'b0, 0, 0);
        run_job(1'b1, 1'b0, 1'b0, 0, 0);
        run_job(1'b0, 1'b1, 1'b0, 0, 0);
`ifdef CTRL_PERF_CNT_EN
        chk("stall_cycles_after_done", longint'(stall_cycles), 3);
`endif
        run_job(1'b0, 1'b0, 1'b1, 0, 0);
`ifdef CTRL_PERF_CNT_EN
        chk("stall_cycles_cleared", longint'(stall_cycles), 0);
`endif
        // Spurious start mid-job is ignored
        run_job(1'b0, 1'b0, 1'b0, 5, 0);

        // Reset at cycle 6 aborts the job
        run_job(1'b0, 1'b0, 1'b0, 0, 6);
        @(negedge clk);
        chk("abort_rd_en", longint'(rd_en), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_init", longint'(init), 0);
        chk("abort_addr_A", longint'(rd_addr_A), 0);
        chk("abort_addr_B", longint'(rd_addr_B), 0);
        @(posedge clk);
        #1;
        run_job(1'b0, 1'b0, 1'b0, 0, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("addr_q_drained", addr_q.size(), 0);
        chk("init0_q_drained", init0_q.size(), 0);
        chk("init3_q_drained", init3_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Parametrised address/init sequencer for the N1×N2 systolic matrix-multiply array. It replaces the free-running control block. It adds the following over that block:
- runtime-latched dimensions and base addresses
- a start/busy/done handshake
- a memory stall input that freezes the whole schedule
- selectable B layout
- a drain phase, so completion is signalled only after the last init has propagated

It sits between the host/command logic and the A/B operand RAMs plus PE array.

## Interface
Parameters:
- N1, 4, PE array rows
- N2, 4, PE array columns
- MATRIXSIZE_W, 16, width of every dimension input and loop counter
- ADDR_W, 16, width of both read addresses

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request, honoured only in IDLE
- M1dN1  in  MATRIXSIZE_W  row-tile count, latched on accepted start
- M2  in  MATRIXSIZE_W  inner dimension K, latched
- M3dN2  in  MATRIXSIZE_W  column-tile count, latched
- a_base  in  ADDR_W  A base address, latched
- b_base  in  ADDR_W  B base address, latched
- b_kmajor  in  1  B layout, latched: 0 = column-of-K contiguous; 1 = K-row contiguous
- stall  in  1  operand memory not ready; freezes schedule
- rd_en  out  1  rd_addr_A/B valid this cycle
- rd_addr_A  out  ADDR_W  A read address
- rd_addr_B  out  ADDR_W  B read address
- init  out  N1*N2  PE accumulator init; bit i*N2+j drives PE(i,j)
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle completion pulse
- stall_cycles  out  32  present only with CTRL_PERF_CNT_EN

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches all configuration inputs.
  - If any of M1dN1, M2 or M3dN2 is zero, go to DONE.
  - Otherwise go to RUN.
- Loop nest, outermost first: r in 0..M1dN1-1, c in 0..M3dN2-1, k in 0..M2-1.
- Counters advance once per RUN cycle with stall=0.
- rd_en = (state==RUN) && !stall.
- rd_addr_A = a_base + r*M2 + k.
- rd_addr_B:
  - b_kmajor=0: b_base + c*M2 + k.
  - b_kmajor=1: b_base + k*M3dN2 + c.
- All address arithmetic is computed at full width, then truncated to ADDR_W. It wraps modulo 2^ADDR_W without flagging.
- Tile-end event: the issue cycle with k==M2-1.
  - A one-bit shift register of depth N1+N2 is loaded with this event.
  - The register advances only on cycles with stall=0.
  - init[i*N2+j] = stage i+j+1, i.e. it asserts i+j+1 advancing cycles after the event.
- RUN→DRAIN: on the issue of the final triple (M1dN1-1, M3dN2-1, M2-1).
- DRAIN: lasts N1+N2 cycles with stall=0, then → DONE.
- DONE: done=1 for one cycle, then → IDLE.
- start outside IDLE is ignored. Configuration inputs are only sampled at an accepted start.

## Timing
- Reset values: state IDLE; rd_en, busy, done, init all 0; rd_addr_A/B 0; counters 0; shift register 0; stall_cycles 0.
- rst asserted mid-operation aborts the job. Reset values appear the cycle after rst is sampled high, and pending init pulses are discarded.
- Cycle numbering: start is accepted at cycle 0.
  - The first rd_en (r=c=k=0) is at cycle 1 if stall=0.
  - The addresses are combinational from the counter registers. The RAM latency is the consumer's concern.
- A stall cycle inserts exactly one cycle into every later event: addresses, init, DRAIN and done.
- stall during IDLE or DONE has no effect.
- Zero-dimension job: done at cycle 1, no rd_en ever asserted.
- The next start is honoured in the cycle after done.

## Configuration
- CTRL_PERF_CNT_EN defined: stall_cycles counts RUN/DRAIN cycles with stall=1.
  - It clears on accepted start.
  - It saturates at 2^32-1.
  - It holds its value after done.
- Macro undefined: the stall_cycles port and its counter are absent. All other behaviour is identical.

## Structure
- ctrl_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - the B-layout constants B_COL_K = 0 and B_ROW_K = 1
  - the perf counter width constant CTRL_PERF_W = 32
- One sub-module, ctrl_loop_cnt: a three-level nested counter (k, c, r) with advance, clear and per-level limit inputs. It outputs the counts plus tile_last and job_last flags.
- The FSM, address arithmetic and init skew shift register live in systolic_ctrl.

## Test plan
- Basic job: N1=N2=2, M1dN1=2, M2=3, M3dN2=2, bases 0, b_kmajor=0, no stall.
  - Expect rd_en at cycles 1–12.
  - A sequence: 0,1,2,0,1,2,3,4,5,3,4,5.
  - B sequence: 0,1,2,3,4,5,0,1,2,3,4,5.
  - init bit 0 at cycles 4, 7, 10, 13.
  - busy high cycles 1–16; done at cycle 17.
- Same job with b_kmajor=1, a_base=100, b_base=200.
  - A sequence: 100,101,102,100,101,102,103,104,105,103,104,105.
  - B sequence: 200,202,204,201,203,205,200,202,204,201,203,205.
- Same job with stall high at cycles 5–7.
  - Address sequence unchanged, rd_en low at cycles 5–7, init bit 0 at cycles 4, 10, 13, 16, done at cycle 20.
  - With CTRL_PERF_CNT_EN: stall_cycles=3.
- M2=0 start → done at cycle 1, busy never high, rd_en never high.
- start re-pulsed at cycle 5 of a running job → ignored, sequence unchanged.
- Back-to-back start at the cycle after done → accepted.
- rst at cycle 6 of the basic job → cycle 7 shows rd_en=0, busy=0, init=0, addresses 0. A new start then reproduces the basic-job sequence exactly.
